// File: rtl/shader_pkg.sv
// Shared constants and helpers for the circle shader pipeline.
// Holds the default circle geometry/colour and the datapath widths.
package shader_pkg;

   localparam int COORD_W = 16;
   localparam int RGB_W   = 24;
   localparam int R_W     = 8;
   localparam int FC_W    = 16;
   localparam int SQ_W    = 32;
   localparam int RR_W    = 16;
   localparam int D2_W    = 33;

   localparam logic [R_W-1:0]   R_MIN_DEF  = 8'd16;
   localparam logic [R_W-1:0]   R_MAX_DEF  = 8'd200;
   localparam logic [R_W-1:0]   R_STEP_DEF = 8'd2;
   localparam logic [RGB_W-1:0] COL_IN_DEF = 24'hFF8000;
   localparam logic [7:0]       BG_BLUE    = 8'h40;

   // Square of a signed coordinate; |-32768|^2 = 2^30 still fits in 32 bits.
   function automatic logic [SQ_W-1:0] square(input logic signed [COORD_W-1:0] v);
      logic signed [SQ_W-1:0] v_ext;
      logic signed [SQ_W-1:0] prod;
      v_ext = SQ_W'(v);
      prod  = v_ext * v_ext;
      return unsigned'(prod);
   endfunction

endpackage

// File: rtl/circle_shader_if.sv
// Pixel stream in/out of the circle shader: ready/valid on both sides.
// slave = shader side, master = stream source and sink side.
interface circle_shader_if;
   import shader_pkg::*;

   logic signed [COORD_W-1:0] in_x;
   logic signed [COORD_W-1:0] in_y;
   logic                      in_first;
   logic                      in_lastx;
   logic                      in_valid;
   logic                      in_ready;
   logic [RGB_W-1:0]          out_data;
   logic                      out_user;
   logic                      out_last;
   logic                      out_valid;
   logic                      out_ready;

   modport slave (
      input  in_x, in_y, in_first, in_lastx, in_valid, out_ready,
      output in_ready, out_data, out_user, out_last, out_valid
   );

   modport master (
      output in_x, in_y, in_first, in_lastx, in_valid, out_ready,
      input  in_ready, out_data, out_user, out_last, out_valid
   );

endinterface

// File: rtl/circle_radius_ctrl.sv
// Per-frame radius sweep and frame counter, advanced on each accepted frame-start beat.
// o_radius_next is the radius the starting frame will use.
module circle_radius_ctrl
   import shader_pkg::*;
#(
   parameter logic [R_W-1:0] R_MIN  = R_MIN_DEF,
   parameter logic [R_W-1:0] R_MAX  = R_MAX_DEF,
   parameter logic [R_W-1:0] R_STEP = R_STEP_DEF
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_frame_start,
   output logic [R_W-1:0]  o_radius,
   output logic [R_W-1:0]  o_radius_next,
   output logic [FC_W-1:0] o_frame_count
);

   logic [R_W-1:0]  r_radius;
   logic [FC_W-1:0] r_frame_count;
   logic [R_W-1:0]  w_radius_next;

   assign w_radius_next = (r_radius >= R_MAX) ? R_MIN : r_radius + R_STEP;

   // Reset to R_MAX so the very first frame wraps to R_MIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_radius      <= R_MAX;
         r_frame_count <= '0;
      end else if (i_frame_start) begin
         r_radius      <= w_radius_next;
         r_frame_count <= r_frame_count + FC_W'(1);
      end
   end

   assign o_radius      = r_radius;
   assign o_radius_next = w_radius_next;
   assign o_frame_count = r_frame_count;

endmodule

// File: rtl/circle_shader.sv
// Three-stage shader: pixels inside a per-frame growing circle get COL_IN,
// others a coordinate gradient. One global stall freezes every stage.
module circle_shader
   import shader_pkg::*;
#(
   parameter logic [R_W-1:0]   R_MIN  = R_MIN_DEF,
   parameter logic [R_W-1:0]   R_MAX  = R_MAX_DEF,
   parameter logic [R_W-1:0]   R_STEP = R_STEP_DEF,
   parameter logic [RGB_W-1:0] COL_IN = COL_IN_DEF
)(
   input  logic            clk,
   input  logic            reset,
   circle_shader_if.slave  bus,
   output logic [FC_W-1:0] frame_count
);

   logic w_adv;
   logic w_frame_start;
   logic [R_W-1:0] w_radius;
   logic [R_W-1:0] w_radius_next;
   logic [R_W-1:0] w_radius_sel;

   logic                      r_s1_valid;
   logic signed [COORD_W-1:0] r_s1_x;
   logic signed [COORD_W-1:0] r_s1_y;
   logic [SQ_W-1:0]           r_s1_xx;
   logic [SQ_W-1:0]           r_s1_yy;
   logic [RR_W-1:0]           r_s1_rr;
   logic                      r_s1_first;
   logic                      r_s1_last;

   logic             r_s2_valid;
   logic [D2_W-1:0]  r_s2_d2;
   logic             r_s2_inside;
   logic [7:0]       r_s2_x8;
   logic [7:0]       r_s2_y8;
   logic             r_s2_first;
   logic             r_s2_last;
   logic [D2_W-1:0]  w_d2;

   logic             r_out_valid;
   logic [RGB_W-1:0] r_out_data;
   logic             r_out_user;
   logic             r_out_last;

   logic w_unused_bits;

   assign w_adv         = !r_out_valid || bus.out_ready;
   assign bus.in_ready  = w_adv;
   assign w_frame_start = bus.in_valid && w_adv && bus.in_first;
   // The frame-start beat is shaded with the radius it is about to install.
   assign w_radius_sel  = bus.in_first ? w_radius_next : w_radius;

   circle_radius_ctrl #(
      .R_MIN  (R_MIN),
      .R_MAX  (R_MAX),
      .R_STEP (R_STEP)
   ) u_radius_ctrl (
      .clk           (clk),
      .reset         (reset),
      .i_frame_start (w_frame_start),
      .o_radius      (w_radius),
      .o_radius_next (w_radius_next),
      .o_frame_count (frame_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         r_s1_xx    <= '0;
         r_s1_yy    <= '0;
         r_s1_rr    <= '0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_x     <= bus.in_x;
            r_s1_y     <= bus.in_y;
            r_s1_xx    <= square(bus.in_x);
            r_s1_yy    <= square(bus.in_y);
            r_s1_rr    <= RR_W'(w_radius_sel) * RR_W'(w_radius_sel);
            r_s1_first <= bus.in_first;
            r_s1_last  <= bus.in_lastx;
         end
      end
   end

   assign w_d2 = {1'b0, r_s1_xx} + {1'b0, r_s1_yy};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_valid  <= 1'b0;
         r_s2_d2     <= '0;
         r_s2_inside <= 1'b0;
         r_s2_x8     <= '0;
         r_s2_y8     <= '0;
         r_s2_first  <= 1'b0;
         r_s2_last   <= 1'b0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_d2     <= w_d2;
            r_s2_inside <= (w_d2 <= D2_W'(r_s1_rr));
            r_s2_x8     <= r_s1_x[7:0];
            r_s2_y8     <= r_s1_y[7:0];
            r_s2_first  <= r_s1_first;
            r_s2_last   <= r_s1_last;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_user  <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_out_data <= r_s2_inside ? COL_IN : {r_s2_x8, r_s2_y8, BG_BLUE};
            r_out_user <= r_s2_first;
            r_out_last <= r_s2_last;
         end
      end
   end

   // Distance and coordinate high bytes are kept for observability only.
   assign w_unused_bits = ^{r_s2_d2, r_s1_x[15:8], r_s1_y[15:8]};

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_user  = r_out_user;
   assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_circle_shader.sv
// Self-checking bench for circle_shader: vector table, scoreboard queue and
// hand sequences for latency, stall, radius sweep and mid-stream reset.
module tb_circle_shader;
   import shader_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic [FC_W-1:0] frame_count;

   circle_shader_if bus ();

   circle_shader dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] data;
      logic        user;
      logic        last;
   } exp_t;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic               first;
      logic               last;
      logic [23:0]        exp_data;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   tx_count = 0;
   int   rx_count = 0;
   exp_t sb_q[$];
   logic [7:0]  r_model;
   exp_t held;
   bit   held_valid = 0;
   bit   rnd_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] shade(input logic signed [15:0] x, input logic signed [15:0] y,
                                         input logic [7:0] r);
      longint d2;
      longint rr;
      d2 = longint'(x) * longint'(x) + longint'(y) * longint'(y);
      rr = longint'(r) * longint'(r);
      if (d2 <= rr) return 24'hFF8000;
      return {x[7:0], y[7:0], 8'h40};
   endfunction

   function automatic logic [7:0] next_r(input logic [7:0] r);
      return (r >= 8'd200) ? 8'd16 : r + 8'd2;
   endfunction

   // Beat is accepted on the next rising edge if in_ready is high at the falling edge.
   task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic first, input logic last,
                       input bit use_exp, input logic [23:0] exp_data);
      bit ok;
      int guard;
      exp_t e;
      bus.in_x = x; bus.in_y = y; bus.in_first = first; bus.in_lastx = last;
      bus.in_valid = 1'b1;
      ok = 0;
      guard = 0;
      while (!ok) begin
         @(negedge clk);
         ok = bus.in_ready;
         if (ok) begin
            if (first) r_model = next_r(r_model);
            e.data = use_exp ? exp_data : shade(x, y, r_model);
            e.user = first;
            e.last = last;
            sb_q.push_back(e);
            tx_count++;
            $display("TX x=%0d y=%0d first=%0b last=%0b exp=%06h", x, y, first, last, e.data);
         end
         @(posedge clk); #1;
         guard++;
         if (!ok && guard > 50) begin
            chk("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk(name, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      sb_q.delete();
      r_model = R_MAX_DEF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Output monitor: scoreboard pop on handshake, stability check while stalled.
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (held_valid)
            chk("hold_stable", 64'({bus.out_data, bus.out_user, bus.out_last}), 64'(held));
         if (bus.out_ready) begin
            held_valid = 0;
            rx_count++;
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 64'({bus.out_data, bus.out_user, bus.out_last}), 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("RX data=%06h user=%0b last=%0b exp=%06h", bus.out_data, bus.out_user,
                        bus.out_last, e.data);
               chk("out_beat", 64'({bus.out_data, bus.out_user, bus.out_last}), 64'(e));
            end
         end else begin
            held = {bus.out_data, bus.out_user, bus.out_last};
            held_valid = 1;
         end
      end else begin
         held_valid = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   lat;
      int   tx0;
      int   rx0;
      logic [7:0] rn;

      vecs[0] = '{16'sd17,     16'sd0,      1'b0, 1'b0, 24'h110040};
      vecs[1] = '{16'sd16,     16'sd0,      1'b0, 1'b0, 24'hFF8000};
      vecs[2] = '{16'sd0,      -16'sd16,    1'b0, 1'b1, 24'hFF8000};
      vecs[3] = '{16'sd12,     16'sd12,     1'b0, 1'b0, 24'h0C0C40};
      vecs[4] = '{-16'sd320,   16'sd240,    1'b1, 1'b1, 24'hC0F040};
      vecs[5] = '{16'sd11,     16'sd11,     1'b0, 1'b0, 24'hFF8000};
      vecs[6] = '{-16'sd13,    -16'sd13,    1'b0, 1'b0, 24'hF3F340};
      vecs[7] = '{-16'sd32768, -16'sd32768, 1'b0, 1'b1, 24'h000040};

      bus.in_x = '0; bus.in_y = '0; bus.in_first = 1'b0; bus.in_lastx = 1'b0;
      bus.out_ready = 1'b1;
      r_model = R_MAX_DEF;
      reset = 1'b1;
      // A frame-start beat offered during reset must not be taken.
      bus.in_valid = 1'b1; bus.in_first = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_user_last", 64'({bus.out_user, bus.out_last}), 64'd0);
      chk("rst_frame_count", 64'(frame_count), 64'd0);
      bus.in_valid = 1'b0; bus.in_first = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_frame_count", 64'(frame_count), 64'd0);

      // First frame beat and its three-cycle latency.
      bus.in_x = 16'sd0; bus.in_y = 16'sd0; bus.in_first = 1'b1; bus.in_lastx = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
      r_model = next_r(r_model);
      sb_q.push_back('{24'hFF8000, 1'b1, 1'b0});
      tx_count++;
      lat = 0;
      while (lat < 10) begin
         @(posedge clk);
         lat++;
         if (lat == 1) begin
            #1 bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (bus.out_valid) break;
      end
      chk("latency", 64'(lat), 64'd3);
      chk("frame_count_1", 64'(frame_count), 64'd1);
      drain("drain_first");

      for (int i = 0; i < 8; i++)
         send(vecs[i].x, vecs[i].y, vecs[i].first, vecs[i].last, 1'b1, vecs[i].exp_data);
      drain("drain_table");
      chk("frame_count_2", 64'(frame_count), 64'd2);

      // Five beats with a four-cycle downstream stall in the middle.
      tx0 = tx_count; rx0 = rx_count;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(16'(i * 5), 16'(-i * 3), 1'b0, (i == 4), 1'b0, 24'h0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (bus.out_valid) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain("drain_stall");
      chk("stall_count", 64'(rx_count - rx0), 64'(tx_count - tx0));

      // Random coordinates against random backpressure.
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 30; i++)
               send(16'($urandom_range(0, 80)) - 16'sd40, 16'($urandom_range(0, 80)) - 16'sd40,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), 1'b0, 24'h0);
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 bus.out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      drain("drain_random");

      // Radius sweep: each frame shades x=r inside and x=r+1 outside.
      do_reset();
      for (int f = 0; f < 94; f++) begin
         rn = 8'(16 + 2 * (f % 93));
         send(16'(rn), 16'sd0, 1'b1, 1'b0, 1'b1, 24'hFF8000);
         send(16'(rn) + 16'sd1, 16'sd0, 1'b0, 1'b1, 1'b1, {rn + 8'd1, 8'h00, 8'h40});
         if (f == 92) chk("frame_count_93", 64'(frame_count), 64'd93);
      end
      drain("drain_sweep");
      chk("frame_count_94", 64'(frame_count), 64'd94);

      // Reset with three beats in flight.
      send(16'sd1, 16'sd1, 1'b1, 1'b0, 1'b0, 24'h0);
      send(16'sd100, 16'sd2, 1'b0, 1'b0, 1'b0, 24'h0);
      send(16'sd3, 16'sd100, 1'b0, 1'b1, 1'b0, 24'h0);
      reset = 1'b1;
      sb_q.delete();
      r_model = R_MAX_DEF;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_frame_count", 64'(frame_count), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      rx0 = rx_count;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_stale", 64'(rx_count - rx0), 64'd0);
      chk("midrst_fc_after", 64'(frame_count), 64'd0);
      send(16'sd16, 16'sd0, 1'b1, 1'b1, 1'b1, 24'hFF8000);
      send(16'sd0, 16'sd17, 1'b0, 1'b0, 1'b1, 24'h001140);
      drain("drain_final");
      chk("frame_count_final", 64'(frame_count), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
